// File: rtl/regfile_wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
package regfile_wbq_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_entry_fifo.sv
// Dual-enqueue, single-dequeue circular buffer of writeback entries.
// Exposes storage, valid bits and head pointer for the forwarding search.
module wbq_entry_fifo
    import regfile_wbq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_i,
    input  wbq_entry_t       entry0_i,
    input  logic             push1_i,
    input  wbq_entry_t       entry1_i,
    input  logic             pop_i,
    output wbq_entry_t       head_o,
    output logic [PTR_W-1:0] head_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output wbq_entry_t       entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    wbq_entry_t       mem_q [DEPTH];
    wbq_entry_t       mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_nxt;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        head_d   = head_q;
        tail_d   = tail_q;
        tail_nxt = tail_q + 1'b1;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        // A lone ALU push takes the tail slot; a pair puts MEM first (older).
        if (push0_i || push1_i) begin
            mem_d[tail_q]   = push0_i ? entry0_i : entry1_i;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_nxt;
        end
        if (push0_i && push1_i) begin
            mem_d[tail_nxt]   = entry1_i;
            valid_d[tail_nxt] = 1'b1;
            tail_d            = tail_nxt + 1'b1;
        end
        count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o     = mem_q[head_q];
    assign head_ptr_o = head_q;
    assign count_o    = count_q;
    assign entries_o  = mem_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue feeding the register file write port, with busy scoreboard.
// Define WBQ_FWD_EN to build the forwarding comparator network.
module regfile_writeback_queue
    import regfile_wbq_pkg::wbq_entry_t;
    import regfile_wbq_pkg::NUM_REGS;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    output logic                rf_reg_write,
    output logic [ADDR_W-1:0]   rf_rd_addr,
    output logic [XLEN-1:0]     rf_write_data,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_rd,
    output logic [NUM_REGS-1:0] busy,
    input  logic [ADDR_W-1:0]   fwd_addr,
    output logic                fwd_hit,
    output logic [XLEN-1:0]     fwd_data,
    output logic [CNT_W-1:0]    count
);

    wbq_entry_t          entry0, entry1, head;
    wbq_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]    fifo_valid;
    logic [PTR_W-1:0]    head_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                ready, push0, push1;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Ready depends only on the start-of-cycle count, so two pushes always fit.
    assign ready     = ~reset & (fifo_count <= CNT_W'(DEPTH - 2));
    assign mem_ready = ready;
    assign alu_ready = ready;
    assign push0     = mem_valid & ready & (mem_rd != '0);
    assign push1     = alu_valid & ready & (alu_rd != '0);

    always_comb begin
        entry0.rd   = mem_rd;
        entry0.data = mem_data;
        entry1.rd   = alu_rd;
        entry1.data = alu_data;
    end

    wbq_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push0_i    (push0),
        .entry0_i   (entry0),
        .push1_i    (push1),
        .entry1_i   (entry1),
        .pop_i      (rf_reg_write),
        .head_o     (head),
        .head_ptr_o (head_ptr),
        .count_o    (fifo_count),
        .entries_o  (entries),
        .valid_o    (fifo_valid)
    );

    assign rf_reg_write  = (fifo_count != '0);
    assign rf_rd_addr    = head.rd;
    assign rf_write_data = head.data;
    assign count         = fifo_count;

    // Set is applied after clear so a same-edge reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_reg_write) begin
            busy_d[rf_rd_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

`ifdef WBQ_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_ptr;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_ptr + PTR_W'(k);
            if (fifo_valid[fwd_idx] && (entries[fwd_idx].rd == fwd_addr) &&
                (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd;

    always_comb begin
        unused_fwd = (^fwd_addr) ^ (^head_ptr) ^ (^fifo_valid);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            unused_fwd = unused_fwd ^ (^entries[k]);
        end
    end

    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule
